// File: rtl/execution_issue_arbiter.sv
// Round-robin issue arbiter: picks one ready instruction queue per cycle and
// feeds a single registered issue slot into a shared execution unit, holding
// off further grants while a multicycle op occupies that unit.
module execution_issue_arbiter #(
  parameter int unsigned NUM_QUEUES    = 3,
  parameter int unsigned MULTI_LATENCY = 4,
  parameter int unsigned ENTRY_W       = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_flush,
  input  logic [NUM_QUEUES-1:0]           i_want_to_execute,
  input  logic [NUM_QUEUES*ENTRY_W-1:0]   i_entry,
  input  logic [NUM_QUEUES-1:0]           i_multicycle,
  input  logic                            i_ex_ready,
  output logic [NUM_QUEUES-1:0]           o_take,
  output logic                            o_issue_valid,
  output logic [ENTRY_W-1:0]              o_issue_entry,
  output logic [$clog2(NUM_QUEUES)-1:0]   o_issue_queue,
  output logic                            o_busy,
  output logic [31:0]                     o_issue_count
);

  localparam int unsigned NQ     = NUM_QUEUES;
  localparam int unsigned QW     = $clog2(NUM_QUEUES);
  localparam int unsigned BUSY_W = 4;

  logic               issue_valid_q, issue_valid_d;
  logic [ENTRY_W-1:0] issue_entry_q, issue_entry_d;
  logic [QW-1:0]      issue_queue_q, issue_queue_d;
  logic [BUSY_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [QW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [31:0]        issue_count_q, issue_count_d;

  logic               can_grant;
  logic               grant_found;
  logic [QW-1:0]      grant_idx;
  logic               consume;

  // (base + off) mod NUM_QUEUES, with off < NUM_QUEUES
  function automatic logic [QW-1:0] wrap_idx(input logic [QW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NQ) s = s - NQ;
    return QW'(s);
  endfunction

  // Grant is allowed only when the slot can move, the unit is idle and no flush/reset
  assign can_grant = (!issue_valid_q || i_ex_ready) && (busy_cnt_q == '0) && !i_flush && !rst;
  assign consume   = issue_valid_q && i_ex_ready && !i_flush;

  // Round-robin search starting at rr_ptr; first requester wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      if (!grant_found && can_grant && i_want_to_execute[wrap_idx(rr_ptr_q, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  assign o_take = grant_found ? (NQ'(1) << grant_idx) : '0;

  // Next-state for the issue slot, occupancy counter, pointer and counter
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_entry_d = issue_entry_q;
    issue_queue_d = issue_queue_q;
    rr_ptr_d      = rr_ptr_q;
    issue_count_d = issue_count_q;
    busy_cnt_d    = (busy_cnt_q != '0) ? busy_cnt_q - BUSY_W'(1) : busy_cnt_q;

    if (consume) begin
      issue_count_d = issue_count_q + 32'd1;
      issue_valid_d = 1'b0;
    end

    if (grant_found) begin
      issue_valid_d = 1'b1;
      issue_entry_d = i_entry[32'(grant_idx)*ENTRY_W +: ENTRY_W];
      issue_queue_d = grant_idx;
      rr_ptr_d      = wrap_idx(grant_idx, 1);
      if (i_multicycle[grant_idx]) busy_cnt_d = BUSY_W'(MULTI_LATENCY);
    end

    if (i_flush) begin
      issue_valid_d = 1'b0;
      busy_cnt_d    = '0;
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_q <= 1'b0;
      issue_entry_q <= '0;
      issue_queue_q <= '0;
      busy_cnt_q    <= '0;
      rr_ptr_q      <= '0;
      issue_count_q <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_entry_q <= issue_entry_d;
      issue_queue_q <= issue_queue_d;
      busy_cnt_q    <= busy_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign o_issue_valid = issue_valid_q;
  assign o_issue_entry = issue_entry_q;
  assign o_issue_queue = issue_queue_q;
  assign o_busy        = (busy_cnt_q != '0);
  assign o_issue_count = issue_count_q;

endmodule

// File: doc/execution_issue_arbiter.md
EXECUTION_ISSUE_ARBITER -- requirements
Module: execution_issue_arbiter

Interface
REQ-001 Parameter NUM_QUEUES, default 3, number of requesting instruction queues, legal range 2..8.
REQ-002 Parameter MULTI_LATENCY, default 4, cycles the shared execution unit stays occupied after issuing a multicycle op, legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 i_flush  input  1  hazard-controller flush.
REQ-006 i_want_to_execute  input  [NUM_QUEUES]  per-queue request, driven by each queue's o_want_to_execute.
REQ-007 i_entry  input  scheduler_entry_t [NUM_QUEUES]  per-queue candidate, driven by each queue's o_next_to_execute.
REQ-008 i_multicycle  input  [NUM_QUEUES]  per-queue flag marking the candidate as a long-latency op, such as divide.
REQ-009 i_ex_ready  input  1  execution unit accepts o_issue_entry this cycle.
REQ-010 o_take  output  [NUM_QUEUES]  combinational one-hot grant, driven to each queue's i_take.
REQ-011 o_issue_valid  output  1  registered issue slot holds a valid entry.
REQ-012 o_issue_entry  output  scheduler_entry_t  registered issued entry.
REQ-013 o_issue_queue  output  $clog2(NUM_QUEUES)  index of the queue that supplied o_issue_entry.
REQ-014 o_busy  output  1  asserted while the multicycle occupancy counter is nonzero.
REQ-015 o_issue_count  output  32  count of entries accepted by the execution unit; wraps modulo 2^32.

Function
REQ-016 can_grant SHALL equal (!o_issue_valid || i_ex_ready) && (busy_cnt == 0) && !i_flush.
REQ-017 When can_grant=1, the block SHALL grant the first requesting queue found searching from rr_ptr upward, modulo NUM_QUEUES.
REQ-018 o_take SHALL be zero when can_grant=0 or no queue requests, and SHALL never have more than one bit set.
REQ-019 o_take SHALL be combinational (same cycle as the request) so the granted queue retires its entry at the same edge.
REQ-020 On a grant to queue g, at the next edge: o_issue_entry <= i_entry[g], o_issue_queue <= g, o_issue_valid <= 1, rr_ptr <= (g+1) mod NUM_QUEUES.
REQ-021 rr_ptr SHALL be unchanged in cycles without a grant.
REQ-022 Handshake: when o_issue_valid=1 and i_ex_ready=1, the entry is consumed; o_issue_count SHALL increment by 1 at that edge.
REQ-023 If the consumption of REQ-022 has no grant in the same cycle, o_issue_valid SHALL clear at that edge.
REQ-024 Back-to-back: consumption and a new grant in the same cycle SHALL replace the slot contents with no bubble.
REQ-025 When o_issue_valid=1 and i_ex_ready=0, o_issue_entry and o_issue_queue SHALL hold stable and no grant SHALL occur.
REQ-026 On a grant with i_multicycle[g]=1, busy_cnt SHALL load MULTI_LATENCY.
REQ-027 Otherwise, busy_cnt SHALL decrement by 1 per cycle while nonzero and saturate at 0.
REQ-028 o_busy SHALL equal (busy_cnt != 0).
REQ-029 With MULTI_LATENCY=4, the next grant is possible no earlier than 5 cycles after a multicycle grant, i.e., 4 dead cycles.
REQ-030 busy_cnt width SHALL be 4 bits.
REQ-031 A multicycle grant SHALL never load busy_cnt while it is nonzero; REQ-016 already guarantees this.
REQ-032 On i_flush=1, o_take SHALL be 0 that cycle, and at the edge: o_issue_valid <= 0 and busy_cnt <= 0.
REQ-033 On i_flush=1, rr_ptr and o_issue_count SHALL hold, and o_issue_entry contents are don't-care.
REQ-034 i_flush concurrent with i_ex_ready=1 SHALL NOT increment o_issue_count.
REQ-035 A request whose queue deasserts i_want_to_execute SHALL simply be skipped; no request state is stored in the block.

Reset
REQ-036 While rst=1 at a posedge, the block SHALL set o_issue_valid=0, o_issue_entry='0, o_issue_queue=0, busy_cnt=0, rr_ptr=0 and o_issue_count=0.
REQ-037 rst SHALL take priority over i_flush and any grant.
REQ-038 o_take SHALL be 0 during any cycle with rst=1.
REQ-039 Reset asserted mid-multicycle or mid-stall SHALL discard all in-flight state at that edge.
REQ-040 The first grant after reset SHALL search from queue 0.

Verification
REQ-041 Scenario: all 3 queues request continuously, i_multicycle=0, i_ex_ready=1. Required: o_take sequence 001,010,100,001; o_issue_count=4 after 5 cycles.
REQ-042 Scenario: queue1 requests with i_multicycle=1 at cycle 0, queue0 requests from cycle 1. Required: o_busy high cycles 1-4, o_take[0] first asserted in cycle 5.
REQ-043 Scenario: slot valid, i_ex_ready=0 for 3 cycles while all queues request. Required: o_take=0 and o_issue_entry stable for 3 cycles; grant in the cycle i_ex_ready returns, with no bubble.
REQ-044 Scenario: i_flush during busy_cnt=3 with o_issue_valid=1 and i_ex_ready=1. Required: o_issue_valid=0 and o_busy=0 next cycle, o_issue_count unchanged, rr_ptr unchanged.
REQ-045 Scenario: rst asserted mid-stream with rr_ptr=2. Required: all REQ-036 values next cycle; the first subsequent grant goes to the lowest requesting index.
REQ-046 Scenario: only queue2 requests, repeatedly. Required: grant to queue2 every cycle; rr_ptr alternates to 0 each time and queue2 is still found by wrap-around search.
